// File: rtl/mnist_pkg.sv
// Shared MNIST front-end definitions: image geometry defaults and the
// input loader state encoding.
package mnist_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int PIX_W      = 8;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOAD,
    COMMIT,
    START,
    WAIT_NN,
    DROP
  } load_state_t;

endpackage

// File: rtl/input_load_ctrl.sv
// Loads one image from a valid/ready byte stream into the pixel buffer,
// checks frame length, then starts the NN core and waits for it to finish.
module input_load_ctrl #(
  parameter int NUM_PIXELS = mnist_pkg::NUM_PIXELS,
  parameter int PIX_W      = mnist_pkg::PIX_W,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [PIX_W-1:0]  buf_data,
  output logic              nn_start,
  input  logic              nn_done,
  output logic              frame_err,
  output logic [15:0]       img_cnt,
  output logic [7:0]        err_cnt
);
  import mnist_pkg::*;

  load_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] pix_cnt_reg;
  logic              buf_wr_en_reg;
  logic [ADDR_W-1:0] buf_addr_reg;
  logic [PIX_W-1:0]  buf_data_reg;
  logic              frame_err_reg, frame_err_next;
  logic [15:0]       img_cnt_reg;
  logic [7:0]        err_cnt_reg;
  logic              accept;
  logic              load_beat;
  logic              at_end;

  assign s_ready   = (state_reg == IDLE) || (state_reg == LOAD) || (state_reg == DROP);
  assign nn_start  = (state_reg == START);
  assign accept    = s_valid && s_ready;
  assign load_beat = accept && ((state_reg == IDLE) || (state_reg == LOAD));
  assign at_end    = (pix_cnt_reg == ADDR_W'(NUM_PIXELS - 1));

  always_comb begin
    state_next     = state_reg;
    frame_err_next = 1'b0;
    case (state_reg)
      INIT: state_next = IDLE;
      IDLE, LOAD: begin
        if (load_beat) begin
          if (at_end) begin
            if (s_last) begin
              state_next = COMMIT;
            end else begin
              frame_err_next = 1'b1;
              state_next     = DROP;
            end
          end else if (s_last) begin
            frame_err_next = 1'b1;
            state_next     = IDLE;
          end else begin
            state_next = LOAD;
          end
        end
      end
      COMMIT:  state_next = START;
      START:   state_next = WAIT_NN;
      WAIT_NN: if (nn_done) state_next = IDLE;
      DROP:    if (accept && s_last) state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      pix_cnt_reg   <= '0;
      buf_wr_en_reg <= 1'b0;
      buf_addr_reg  <= '0;
      buf_data_reg  <= '0;
      frame_err_reg <= 1'b0;
      img_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      buf_wr_en_reg <= load_beat;
      frame_err_reg <= frame_err_next;
      if (load_beat) begin
        buf_addr_reg <= pix_cnt_reg;
        buf_data_reg <= s_data;
      end
      // Any path back to IDLE restarts addressing, including a one-beat short frame.
      if (state_next == IDLE)
        pix_cnt_reg <= '0;
      else if (load_beat)
        pix_cnt_reg <= pix_cnt_reg + 1'b1;
      if (frame_err_next && (err_cnt_reg != 8'hFF))
        err_cnt_reg <= err_cnt_reg + 8'd1;
      if (state_reg == START)
        img_cnt_reg <= img_cnt_reg + 16'd1;
    end
  end

  assign buf_wr_en = buf_wr_en_reg;
  assign buf_addr  = buf_addr_reg;
  assign buf_data  = buf_data_reg;
  assign frame_err = frame_err_reg;
  assign img_cnt   = img_cnt_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_input_load_ctrl.sv
// Directed bench for input_load_ctrl: a cycle table for short frames plus
// full-frame sequences for nominal, gapped, oversize and reset-abort cases.
module tb_input_load_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       buf_wr_en;
  logic [9:0] buf_addr;
  logic [7:0] buf_data;
  logic       nn_start;
  logic       nn_done = 1'b0;
  logic       frame_err;
  logic [15:0] img_cnt;
  logic [7:0]  err_cnt;

  input_load_ctrl #(.NUM_PIXELS(784), .PIX_W(8), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .buf_wr_en(buf_wr_en), .buf_addr(buf_addr), .buf_data(buf_data),
    .nn_start(nn_start), .nn_done(nn_done), .frame_err(frame_err),
    .img_cnt(img_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int ferr_cnt = 0;
  int ferr_cyc = -1;
  int acc_cyc[1024];
  logic [17:0] wr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (buf_wr_en) wr_q.push_back({buf_addr, buf_data});
      if (nn_start) start_cnt++;
      if (frame_err) begin
        ferr_cnt++;
        ferr_cyc = cyc;
      end
    end
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       done;
    logic       e_ready;
    logic       e_wr;
    logic [9:0] e_addr;
    logic [7:0] e_data;
    logic       e_start;
    logic       e_ferr;
    logic [7:0] e_err;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {18'd0, s_ready, buf_wr_en, buf_addr, buf_data, nn_start, frame_err, img_cnt, err_cnt};
  endfunction

  task automatic clear_mon();
    wr_q.delete();
    start_cnt = 0;
    ferr_cnt  = 0;
    ferr_cyc  = -1;
  endtask

  // Beat i carries data i[7:0]; returns #1 after the edge following the last accepted beat.
  task automatic send_beats(input int n, input int last_at, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      int  waited = 0;
      bit  got = 0;
      while (!got) begin
        @(negedge clk);
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
          s_valid = 1'b0;
        end else begin
          s_valid = 1'b1;
          s_data  = i[7:0];
          s_last  = (i == last_at);
          if (s_ready) begin
            got = 1;
            acc_cyc[i] = cyc + 1;
          end
        end
        waited++;
        if (!got && waited > 500) begin
          checks++;
          errors++;
          $display("FAIL beat_timeout: beat %0d not accepted, required within 500 cycles", i);
          s_valid = 1'b0;
          s_last  = 1'b0;
          return;
        end
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_writes(input int n);
    int bad = 0;
    int lim;
    check("wr_count", wr_q.size(), n);
    lim = (wr_q.size() < n) ? wr_q.size() : n;
    for (int i = 0; i < lim; i++) begin
      logic [9:0] a = i[9:0];
      logic [7:0] d = i[7:0];
      if (wr_q[i] !== {a, d}) bad++;
    end
    check("wr_order_bad", bad, 0);
  endtask

  // Called during COMMIT: ready must stay low until nn_done is seen in WAIT_NN.
  task automatic release_core();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("hold_ready", s_ready, 0);
    end
    @(negedge clk);
    nn_done = 1'b1;
    @(posedge clk);
    #1;
    check("done_ready", s_ready, 1);
    nn_done = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 8'hAA, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 8'hAA, 1'b0, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b1, 10'd1, 8'hBB, 1'b0, 1'b0, 8'd0};
    tbl[3] = '{1'b1, 8'hCC, 1'b1, 1'b0, 1'b1, 1'b1, 10'd2, 8'hCC, 1'b0, 1'b1, 8'd1};
    tbl[4] = '{1'b1, 8'hDD, 1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 8'hDD, 1'b0, 1'b1, 8'd2};
    tbl[5] = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 8'hDD, 1'b0, 1'b0, 8'd2};

    // Reset and INIT cycle
    #1 rst_n = 1'b0;
    #1 check("rst_outs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("init_outs", all_outs(), 0);
    @(posedge clk);
    #1 check("idle_ready", s_ready, 1);

    // Cycle table: short frames of 3 and 1 beats, stall, stray nn_done
    foreach (tbl[r]) begin
      @(negedge clk);
      s_valid = tbl[r].v;
      s_data  = tbl[r].d;
      s_last  = tbl[r].l;
      nn_done = tbl[r].done;
      @(posedge clk);
      #1;
      check($sformatf("t%0d_ready", r), s_ready, tbl[r].e_ready);
      check($sformatf("t%0d_wr", r), buf_wr_en, tbl[r].e_wr);
      check($sformatf("t%0d_addr", r), buf_addr, tbl[r].e_addr);
      check($sformatf("t%0d_data", r), buf_data, tbl[r].e_data);
      check($sformatf("t%0d_start", r), nn_start, tbl[r].e_start);
      check($sformatf("t%0d_ferr", r), frame_err, tbl[r].e_ferr);
      check($sformatf("t%0d_errcnt", r), err_cnt, tbl[r].e_err);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    nn_done = 1'b0;

    // Nominal frame, back-to-back
    clear_mon();
    send_beats(784, 783, 0);
    check("nom_commit_wr", buf_wr_en, 1);
    check("nom_commit_addr", buf_addr, 783);
    check("nom_commit_ready", s_ready, 0);
    check("nom_commit_start", nn_start, 0);
    @(posedge clk);
    #1 check("nom_start", nn_start, 1);
    @(posedge clk);
    #1 check("nom_start_end", nn_start, 0);
    check("nom_img_cnt", img_cnt, 1);
    release_core();
    check_writes(784);
    check("nom_start_cnt", start_cnt, 1);

    // Gapped frame with nn_done held high through START
    clear_mon();
    send_beats(784, 783, 50);
    nn_done = 1'b1;
    @(posedge clk);
    #1 check("gap_start", nn_start, 1);
    @(posedge clk);
    #1 check("gap_wait_ready", s_ready, 0);
    @(posedge clk);
    #1 check("gap_exit_ready", s_ready, 1);
    nn_done = 1'b0;
    check_writes(784);
    check("gap_start_cnt", start_cnt, 1);
    check("gap_img_cnt", img_cnt, 2);

    // Short frame, then a nominal frame restarting at address 0
    clear_mon();
    send_beats(100, 99, 0);
    check("short_ferr", frame_err, 1);
    check("short_ready", s_ready, 1);
    @(posedge clk);
    #1 check("short_ferr_end", frame_err, 0);
    check_writes(100);
    check("short_start_cnt", start_cnt, 0);
    check("short_err_cnt", err_cnt, 3);
    clear_mon();
    send_beats(784, 783, 0);
    release_core();
    check_writes(784);
    check("after_short_img", img_cnt, 3);

    // Oversize frame
    clear_mon();
    send_beats(800, 799, 0);
    check("over_ready", s_ready, 1);
    check("over_wr", buf_wr_en, 0);
    check_writes(784);
    check("over_ferr_cnt", ferr_cnt, 1);
    check("over_ferr_cyc", ferr_cyc, acc_cyc[783]);
    check("over_start_cnt", start_cnt, 0);
    check("over_err_cnt", err_cnt, 4);

    // Reset mid-frame at beat 400
    clear_mon();
    send_beats(401, -1, 0);
    check("mid_wr_addr", buf_addr, 400);
    #1 rst_n = 1'b0;
    #1 check("midrst_outs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_init_outs", all_outs(), 0);
    clear_mon();
    send_beats(784, 783, 0);
    release_core();
    check_writes(784);
    check("midrst_img_cnt", img_cnt, 1);
    check("midrst_err_cnt", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_load_ctrl.md
# input_load_ctrl

Sequences one MNIST image (NUM_PIXELS 8-bit pixels) from an upstream valid/ready byte stream into the pixel buffer. It generates buffer write enable, address and data. When the frame is complete and correctly delimited, it pulses `nn_start` to the network core. It then holds off upstream until the core reports `nn_done`. The block sits between the input interface and the pixel buffer / NN core, and also checks frame length.

## Interface
- `NUM_PIXELS`, 784, pixels per image.
- `PIX_W`, 8, pixel width.
- `ADDR_W`, 10, buffer address width; must satisfy 2^ADDR_W ≥ NUM_PIXELS.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  PIX_W  pixel from upstream.
- `s_valid`  in  1  upstream beat valid.
- `s_last`  in  1  marks the final beat of a frame.
- `s_ready`  out  1  block accepts a beat; a beat transfers when `s_valid && s_ready`.
- `buf_wr_en`  out  1  pixel buffer write strobe.
- `buf_addr`  out  ADDR_W  pixel buffer write address.
- `buf_data`  out  PIX_W  pixel buffer write data.
- `nn_start`  out  1  one-cycle pulse: image is complete in the buffer.
- `nn_done`  in  1  core finished with the buffer; a one-cycle pulse or a level, both accepted.
- `frame_err`  out  1  one-cycle pulse: frame length error.
- `img_cnt`  out  16  images started; wraps at 2^16.
- `err_cnt`  out  8  frame errors; saturates at 255.

## Operation
- **States**
  - INIT: reset state. Exits to IDLE after one cycle.
  - IDLE, LOAD: `s_ready`=1.
  - COMMIT, START, WAIT_NN: `s_ready`=0.
  - DROP: `s_ready`=1.
- **Pixel counter** `pix_cnt` (ADDR_W bits) holds the index of the next beat.
  - Cleared on entry to IDLE.
  - Incremented on each accepted beat in IDLE or LOAD.
- **Accepted beat in IDLE or LOAD, index i**
  - The registered write fires next cycle: `buf_addr`=i, `buf_data`=`s_data`.
  - IDLE moves to LOAD on the first beat.
- **i = NUM_PIXELS-1 and `s_last`=1:** go to COMMIT, then START, then WAIT_NN.
- **i = NUM_PIXELS-1 and `s_last`=0 (oversize frame)**
  - Pulse `frame_err` and go to DROP.
  - DROP discards beats with no writes until a beat with `s_last`=1 is accepted, then returns to IDLE.
  - No `nn_start` is issued.
- **i < NUM_PIXELS-1 and `s_last`=1 (short frame)**
  - The pixel is still written.
  - Pulse `frame_err` and return to IDLE.
  - The image is discarded and no `nn_start` is issued.
- **START:** `nn_start`=1 and `img_cnt`+=1 (wrapping).
- **WAIT_NN:** on `nn_done`=1, go to IDLE next cycle. `nn_done` in any other state is ignored.
- **Error counting:** `err_cnt`+=1 on every `frame_err`, saturating at 255.
- **`buf_addr` and `buf_data`** hold their last values when `buf_wr_en`=0.

## Timing
- **Reset values:** while `rst_n`=0, and in the first cycle after release (INIT), every output is 0. This includes `s_ready`, all counters, `buf_*`, `nn_start` and `frame_err`.
- **Write latency:** beat accepted in cycle k → `buf_wr_en`=1 in cycle k+1.
  - Back-to-back beats give back-to-back writes; full throughput is 1 pixel per cycle.
- **Last beat in cycle k:** `buf_wr_en` in k+1 (COMMIT), `nn_start` in k+2 (START), `s_ready`=0 from k+1.
- **`frame_err`** is high in the cycle after the offending beat.
- **`nn_done` in cycle m while in WAIT_NN:** IDLE and `s_ready`=1 in cycle m+1.
  - `nn_done` asserted in the START cycle is ignored; the block must see it in WAIT_NN.
- **`s_valid` low mid-frame:** stalls with no state change and no write. There is no timeout.
- **Reset mid-frame:** asynchronous return to INIT.
  - Partial image abandoned; counters cleared; any in-flight write is dropped.
- **Short frame of one beat** (i=0, `s_last`=1): one write, one `frame_err`, back to IDLE.

## Structure
- Shared package `mnist_pkg` holds:
  - `NUM_PIXELS` and `PIX_W` defaults;
  - the state enum `load_state_t` {INIT, IDLE, LOAD, COMMIT, START, WAIT_NN, DROP}.
- No sub-module.
  - FSM, pixel counter, write register and status counters are inline.
  - The pixel buffer is instantiated outside, at the parent level.

## Test plan
- **Reset then nominal frame:** 784 back-to-back beats, `s_data`=i[7:0], `s_last` on beat 783.
  - 784 writes with `buf_addr` 0..783.
  - `nn_start` exactly 2 cycles after the last beat; `img_cnt`=1; `s_ready`=0 until `nn_done`.
- **Random `s_valid` gaps (50%) across a full frame:**
  - Writes match accepted beats 1:1 in order.
  - Exactly one `nn_start`.
- **Short frame:** `s_last` on beat 99.
  - 100 writes, `frame_err` pulse, `err_cnt`=1, no `nn_start`.
  - The next nominal frame starts at `buf_addr` 0.
- **Oversize frame:** 800 beats with `s_last` on beat 799.
  - `frame_err` the cycle after beat 783; no writes for beats 784..799; no `nn_start`.
  - Returns to IDLE.
- **`nn_done` held high through START:**
  - No early exit; exits WAIT_NN the next cycle.
  - A second frame is accepted only after that.
- **Reset asserted at beat 400:**
  - All outputs 0 immediately.
  - After release, a nominal frame completes with `img_cnt`=1.
